lcd_segment_capture: RTL
========================

LCD_SEGMENT_CAPTURE -- requirements
Module: lcd_segment_capture

Interface
REQ-001 SHALL have parameter SETTLE_TICKS, default 4, meaning the number of clk_en ticks after a strobe change before sampling; legal range 1..1023.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of record FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clk_en  input  1  32.768 kHz CPU tick enable.
REQ-006 SHALL have port lcd_h  input  4  CPU LCD common strobe, one-hot when valid.
REQ-007 SHALL have ports segment_a and segment_b, each input  16  CPU segment lines for the current H.
REQ-008 SHALL have port segment_bs  input  1  CPU comb segment for the current H.
REQ-009 SHALL have port out_valid  output  1  record available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the record.
REQ-011 SHALL have port out_h  output  2  H index (0 for H1 through 3 for H4).
REQ-012 SHALL have ports out_a and out_b, each output  16  captured segment_a and segment_b.
REQ-013 SHALL have port out_bs  output  1  captured segment_bs.
REQ-014 SHALL have port out_sof  output  1  asserted with a record whose out_h is 0, marking start of frame.
REQ-015 SHALL have port overflow  output  1  sticky flag set when a record is dropped.

Function
REQ-016 SHALL register lcd_h into prev_h on every clk_en tick; a "strobe change" is a clk_en tick where lcd_h differs from prev_h.
REQ-017 SHALL implement states IDLE and SETTLE, with settle counter cnt of 10 bits.
REQ-018 IDLE: a strobe change to a one-hot lcd_h SHALL latch its index into cur_h, clear cnt to 0, and enter SETTLE.
REQ-019 SETTLE, per clk_en tick with no strobe change: cnt SHALL increment; on the tick where cnt becomes SETTLE_TICKS, the block SHALL sample segment_a, segment_b, segment_bs and cur_h, attempt a push, and return to IDLE.
REQ-020 SETTLE, strobe change to another one-hot value: SHALL relatch cur_h, clear cnt to 0, and remain in SETTLE (restart).
REQ-021 Any state, strobe change to a non-one-hot value (0 or multiple bits): SHALL enter IDLE with no sample.
REQ-022 State and counters SHALL only advance on clk_en; FIFO pops SHALL occur on any clk cycle.
REQ-023 Push SHALL succeed if the FIFO is not full, or if the FIFO is full and a pop occurs in the same cycle.
REQ-024 Otherwise the record SHALL be dropped and overflow set to 1.
REQ-025 A pushed record SHALL appear on out_* with out_valid=1 starting the cycle after the push if the FIFO was empty (1-cycle latency).
REQ-026 out_* SHALL show the oldest entry and remain stable while out_valid=1 and out_ready=0.
REQ-027 A pop SHALL occur exactly on a cycle where out_valid=1 and out_ready=1; out_ready while out_valid=0 SHALL have no effect.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 out_sof SHALL equal (out_h == 0) while out_valid=1, and SHALL be 0 otherwise.

Reset
REQ-030 On reset: state=IDLE, cnt=0, prev_h=0, FIFO empty, out_valid=0, out_h=0, out_a=0, out_b=0, out_bs=0, out_sof=0, overflow=0.
REQ-031 Reset mid-SETTLE SHALL discard the pending sample; the first tick after reset with a one-hot lcd_h SHALL count as a strobe change.
REQ-032 overflow SHALL clear only on reset.

Configuration
REQ-033 Macro LCD_CAPTURE_CHANGE_FILTER_EN: when defined, the block SHALL keep the last pushed {a,b,bs} per H index, cleared to invalid on reset.
REQ-034 With LCD_CAPTURE_CHANGE_FILTER_EN defined, a sample equal to the stored value for the same valid H SHALL be discarded silently, without a push and without setting overflow.
REQ-035 With LCD_CAPTURE_CHANGE_FILTER_EN undefined, every completed sample SHALL attempt a push and no per-H storage SHALL exist.

Verification
REQ-036 Scenario: lcd_h 0001, a=16'h1234, b=16'hABCD, bs=1, out_ready=1, SETTLE_TICKS=4 -> exactly one record out_h=0, out_a=1234, out_b=ABCD, out_bs=1, out_sof=1, emitted after the 4th clk_en tick.
REQ-037 Scenario: strobe sequence H1,H2,H4,H8 every 1024 ticks -> records out_h 0,1,2,3 in order; out_sof=1 only on the first.
REQ-038 Scenario: lcd_h changes 0001 to 0010 at tick 2 of settle -> single record out_h=1; no out_h=0 record.
REQ-039 Scenario: out_ready=0 with 5 phases at FIFO_DEPTH=4 -> 4 records held, overflow=1, and after draining the records are phases 1-4 unchanged.
REQ-040 Scenario: lcd_h 0011 or 0000 -> no record, state IDLE.
REQ-041 Scenario: with LCD_CAPTURE_CHANGE_FILTER_EN, two full frames of identical segments -> 4 records only; then change a on H3 to 16'h0001 -> one further record out_h=2.

Source files
------------

// File: rtl/lcd_segment_capture.sv
// lcd_segment_capture
// Watches the CPU LCD common strobe (lcd_h) on the 32.768 kHz tick enable.
// After a one-hot strobe has been stable for SETTLE_TICKS ticks, the segment
// lines for that common are sampled into a small record FIFO for a consumer.
// A record that finds the FIFO full (and no pop in the same cycle) is dropped
// and the sticky overflow flag is raised.
//
// Optional feature, macro LCD_CAPTURE_CHANGE_FILTER_EN: remembers the last
// pushed {a,b,bs} per H index and silently discards samples that repeat it.
// With the macro undefined every completed sample attempts a push.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A record
// transfers on exactly the cycles where both are high; while out_valid=1 and
// out_ready=0 every out_* field holds steady; out_ready with out_valid=0 is
// ignored. out_valid never drops without a transfer.
//
// o_dbg_state mirrors the capture FSM state (0 = IDLE, 1 = SETTLE).

module lcd_segment_capture #(
  parameter int SETTLE_TICKS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [3:0]  lcd_h,
  input  logic [15:0] segment_a,
  input  logic [15:0] segment_b,
  input  logic        segment_bs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_h,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic        out_bs,
  output logic        out_sof,
  output logic        overflow,
  output logic        o_dbg_state
);

  // Record layout: {h[1:0], a[15:0], b[15:0], bs}
  localparam int RW = 35;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [9:0]    SETTLE_C = 10'(SETTLE_TICKS);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Strobe tracking and capture FSM
  // ---------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_prev_h;
  logic [1:0]  r_cur_h;
  logic [1:0]  w_cur_h_next;
  logic [9:0]  r_cnt;
  logic [9:0]  w_cnt_next;
  logic        w_change;
  logic        w_onehot;
  logic [1:0]  w_h_idx;
  logic        w_sample;

  assign w_change = clk_en && (lcd_h != r_prev_h);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot = (lcd_h != 4'd0) && ((lcd_h & (lcd_h - 4'd1)) == 4'd0);

  // Encode the one-hot strobe into an H index (only used when w_onehot).
  always_comb begin
    w_h_idx = 2'd0;
    case (lcd_h)
      4'b0001: w_h_idx = 2'd0;
      4'b0010: w_h_idx = 2'd1;
      4'b0100: w_h_idx = 2'd2;
      4'b1000: w_h_idx = 2'd3;
      default: w_h_idx = 2'd0;
    endcase
  end

  // Previous strobe value, updated on every tick; reset to 0 so the first
  // one-hot strobe after reset is seen as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_h <= 4'd0;
    end else if (clk_en) begin
      r_prev_h <= lcd_h;
    end
  end

  // FSM state register together with the settle counter and latched H.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 10'd0;
      r_cur_h <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cur_h <= w_cur_h_next;
    end
  end

  // Next-state logic: a strobe change always wins over settle counting, so a
  // change on the would-be sampling tick restarts (one-hot) or aborts.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cur_h_next = r_cur_h;
    w_sample     = 1'b0;
    if (clk_en) begin
      if (w_change) begin
        w_cnt_next = 10'd0;
        if (w_onehot) begin
          w_state_next = S_SETTLE;
          w_cur_h_next = w_h_idx;
        end else begin
          w_state_next = S_IDLE;
        end
      end else if (r_state == S_SETTLE) begin
        w_cnt_next = r_cnt + 10'd1;
        if ((r_cnt + 10'd1) == SETTLE_C) begin
          w_sample     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
    end
  end

  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------
  // Sample record and optional repeat filter
  // ---------------------------------------------------------------------
  logic [RW-1:0] w_rec;
  logic          w_filtered;
  logic          w_push_req;
  logic          w_push;

  assign w_rec      = {r_cur_h, segment_a, segment_b, segment_bs};
  assign w_push_req = w_sample && !w_filtered;

`ifdef LCD_CAPTURE_CHANGE_FILTER_EN
  logic [32:0] r_last [4];
  logic [3:0]  r_last_vld;

  assign w_filtered = r_last_vld[r_cur_h] &&
                      (r_last[r_cur_h] == {segment_a, segment_b, segment_bs});

  // Remember the last record actually written for each H; a dropped record
  // was never delivered, so it does not update the stored value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_vld <= 4'd0;
    end else if (w_push) begin
      r_last_vld[r_cur_h] <= 1'b1;
      r_last[r_cur_h]     <= {segment_a, segment_b, segment_bs};
    end
  end
`else
  assign w_filtered = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Record FIFO
  // ---------------------------------------------------------------------
  logic [RW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_pop;
  logic          w_full;
  logic          w_drop;
  logic [RW-1:0] w_head;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_count == DEPTH_C);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_drop    = w_push_req && !w_push;

  // Storage write; contents need no reset because out_valid gates the view.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // Pointers, occupancy and sticky overflow. Pointers wrap naturally since
  // the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign overflow = r_overflow;

  // Present the oldest record; all fields read as zero while empty.
  always_comb begin
    out_h   = 2'd0;
    out_a   = 16'd0;
    out_b   = 16'd0;
    out_bs  = 1'b0;
    out_sof = 1'b0;
    if (out_valid) begin
      out_h   = w_head[34:33];
      out_a   = w_head[32:17];
      out_b   = w_head[16:1];
      out_bs  = w_head[0];
      out_sof = (w_head[34:33] == 2'd0);
    end
  end

endmodule
